step_conditioner: RTL and testbench
===================================

// Module: step_conditioner
// PURPOSE
//   Upstream conditioning stage for the sequence-detector FSM pair (one-hot and binary).
//   Synchronises and debounces the raw step pushbutton into a single-cycle step enable.
//   Synchronises the w switch and samples it on that same cycle.
//   Downstream FSMs run on clk and advance only when step=1, with w_out as their input.
// PARAMETERS
//   DEBOUNCE_CYCLES  1_000_000  consecutive stable cycles required to accept an edge (>=2)
//   SYNC_STAGES      2          flip-flop stages in each input synchroniser (>=2)
// PORTS
//   clk          input   1   system clock; all logic on rising edge
//   reset        input   1   synchronous, active-high reset
//   btn_raw      input   1   raw, bouncy, asynchronous step pushbutton
//   sw_raw       input   1   raw asynchronous w switch
//   step         output  1   one-cycle pulse per accepted button press
//   w_out        output  1   synchronised sw value captured on the step cycle; held between steps
//   btn_level    output  1   debounced button level (1 in PRESSED/RELEASE_WAIT)
//   press_count  output  8   accepted-press counter, wraps 255->0
//   state        output  2   FSM state code, for debug LEDs
// BEHAVIOUR
//   Reset (clk edge with reset=1) forces all of the following:
//     - sync flops = 0, cnt = 0, state = IDLE
//     - step = 0, w_out = 0, press_count = 0
//     - Reset overrides every other event in the same cycle.
//   Synchronisers: btn_sync / sw_sync are the last stage of SYNC_STAGES-deep chains.
//     - A raw change is visible on btn_sync SYNC_STAGES edges after it is first sampled.
//   Counter: cnt is $clog2(DEBOUNCE_CYCLES) bits wide and never exceeds DEBOUNCE_CYCLES-1.
//   FSM encoding: IDLE=2'b00, PRESS_WAIT=2'b01, PRESSED=2'b10, RELEASE_WAIT=2'b11.
//     IDLE:
//       - btn_sync=1 -> PRESS_WAIT, cnt<=0
//     PRESS_WAIT:
//       - btn_sync=0 -> IDLE, cnt<=0 (bounce rejected, no pulse)
//       - btn_sync=1 and cnt==DEBOUNCE_CYCLES-1 -> PRESSED; on that edge:
//         step<=1, w_out<=sw_sync, press_count<=press_count+1
//       - otherwise cnt<=cnt+1
//     PRESSED:
//       - btn_sync=0 -> RELEASE_WAIT, cnt<=0
//       - else stay; button held indefinitely gives exactly one step
//     RELEASE_WAIT:
//       - btn_sync=1 -> PRESSED, cnt<=0 (release bounce, no pulse)
//       - btn_sync=0 and cnt==DEBOUNCE_CYCLES-1 -> IDLE
//       - else cnt<=cnt+1
//   step: registered; high for exactly one cycle, then cleared on the next edge.
//   Press latency: first edge sampling btn_raw=1 is e0. With a clean press:
//     - step rises at edge e0+SYNC_STAGES+DEBOUNCE_CYCLES
//     - step falls one edge later
//   Press spacing: two steps are separated by at least 2*DEBOUNCE_CYCLES+2 cycles.
//   w_out: changes only on a step edge; sw_raw toggling between steps never alters it.
//   Button held through reset release: seen as a fresh press; one step after full latency.
//   No combinational path from any input to any output.
// TESTING (DEBOUNCE_CYCLES=4, SYNC_STAGES=2)
//   1. Clean press: btn_raw 0->1 sampled at e0, held 20 cycles.
//      -> step=1 only in the cycle after e0+6; press_count=1; btn_level=1 from e0+6.
//   2. Press bounce: btn_raw 1,1,0,1,1,0 then steady 1.
//      -> no step until 4 consecutive btn_sync=1 cycles; exactly one step; press_count=1.
//   3. Release bounce: from PRESSED, btn_raw 0,1,0,0,1 then steady 0.
//      -> no step; state returns IDLE only after 4 stable-0 cycles; a new press then gives one step.
//   4. w capture: sw_raw=1 settled before press #1, sw_raw=0 before press #2, sw toggled between presses.
//      -> w_out=1 from step#1 to step#2, then 0; never changes otherwise.
//   5. Reset mid-operation: reset=1 for 1 cycle while in PRESS_WAIT with cnt=2.
//      -> state=IDLE, cnt=0, no step from the aborted press; press_count=0; w_out=0.
//   6. Wrap: 256 clean presses.
//      -> press_count 255->0 on the 256th step; one step per press; no missed or double pulses.

Source files
------------

// File: rtl/step_conditioner_if.sv
// Pushbutton/switch conditioning bundle: raw inputs in, conditioned step/w and debug status out.
interface step_conditioner_if;
  logic       btn_raw;
  logic       sw_raw;
  logic       step;
  logic       w_out;
  logic       btn_level;
  logic [7:0] press_count;
  logic [1:0] state;

  // Board/stimulus side: drives the raw inputs, observes the conditioned outputs.
  modport master (
    output btn_raw,
    output sw_raw,
    input  step,
    input  w_out,
    input  btn_level,
    input  press_count,
    input  state
  );

  // Conditioner side: samples the raw inputs, drives the conditioned outputs.
  modport slave (
    input  btn_raw,
    input  sw_raw,
    output step,
    output w_out,
    output btn_level,
    output press_count,
    output state
  );
endinterface

// File: rtl/step_conditioner.sv
// Step conditioner: synchronises and debounces the step pushbutton into a one-cycle
// step enable, and captures the synchronised w switch on that same cycle.
module step_conditioner #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int SYNC_STAGES     = 2
) (
  input logic               clk,
  input logic               reset,
  step_conditioner_if.slave bus
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  localparam logic [1:0] IDLE         = 2'b00;
  localparam logic [1:0] PRESS_WAIT   = 2'b01;
  localparam logic [1:0] PRESSED      = 2'b10;
  localparam logic [1:0] RELEASE_WAIT = 2'b11;

  logic [SYNC_STAGES-1:0] btn_sync_q;
  logic [SYNC_STAGES-1:0] sw_sync_q;
  logic                   btn_sync;
  logic                   sw_sync;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             step_q, step_d;
  logic             w_q, w_d;
  logic [7:0]       count_q, count_d;

  // Input synchronisers: shift each raw input through its own flop chain.
  always_ff @(posedge clk) begin
    if (reset) begin
      btn_sync_q <= {SYNC_STAGES{1'b0}};
      sw_sync_q  <= {SYNC_STAGES{1'b0}};
    end else begin
      btn_sync_q <= {btn_sync_q[SYNC_STAGES-2:0], bus.btn_raw};
      sw_sync_q  <= {sw_sync_q[SYNC_STAGES-2:0], bus.sw_raw};
    end
  end

  assign btn_sync = btn_sync_q[SYNC_STAGES-1];
  assign sw_sync  = sw_sync_q[SYNC_STAGES-1];

  // Debounce FSM next state: an edge is accepted only after the counter has seen the
  // new level stable for the full window; any disagreement falls back without a pulse.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    step_d  = 1'b0;
    w_d     = w_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (btn_sync) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = CNT_ZERO;
        end
      end
      PRESS_WAIT: begin
        if (!btn_sync) begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_MAX) begin
          state_d = PRESSED;
          cnt_d   = CNT_ZERO;
          step_d  = 1'b1;
          w_d     = sw_sync;
          count_d = count_q + 8'd1;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      PRESSED: begin
        if (!btn_sync) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = PRESSED;
        end
      end
      RELEASE_WAIT: begin
        if (btn_sync) begin
          state_d = PRESSED;
          cnt_d   = CNT_ZERO;
        end else if (cnt_q == CNT_MAX) begin
          state_d = IDLE;
          cnt_d   = CNT_ZERO;
        end else begin
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // FSM, counter and output registers; reset wins over every other event.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= CNT_ZERO;
      step_q  <= 1'b0;
      w_q     <= 1'b0;
      count_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      step_q  <= step_d;
      w_q     <= w_d;
      count_q <= count_d;
    end
  end

  assign bus.step        = step_q;
  assign bus.w_out       = w_q;
  assign bus.btn_level   = state_q[1];
  assign bus.press_count = count_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_step_conditioner.sv
// Bench for step_conditioner (DEBOUNCE_CYCLES=4, SYNC_STAGES=2): a hand-derived
// per-cycle vector table, directed corner-case sequences and a random phase, all
// compared every cycle against a run-length reference model.
module tb_step_conditioner;
  localparam int D = 4;
  localparam int S = 2;

  logic clk = 1'b0;
  logic rst;

  step_conditioner_if bus();

  step_conditioner #(.DEBOUNCE_CYCLES(D), .SYNC_STAGES(S)) dut (
    .clk   (clk),
    .reset (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int steps_seen = 0;

  // Reference model: the synchronised input is the raw input S samples late; the
  // debounced level flips after D+1 consecutive synchronised samples disagreeing with it.
  bit mq_btn[$];
  bit mq_sw[$];
  bit m_level, m_step, m_w;
  int m_run, m_count;

  typedef struct packed {
    logic       rst, btn, sw;
    logic       step, w, lvl;
    logic [7:0] cnt;
    logic [1:0] st;
  } vec_t;

  vec_t tbl[19];

  function automatic vec_t v(input logic r, b, s, e_step, e_w, e_lvl, input int c, input logic [1:0] q);
    vec_t x;
    x.rst = r; x.btn = b; x.sw = s; x.step = e_step; x.w = e_w; x.lvl = e_lvl;
    x.cnt = c[7:0]; x.st = q;
    return x;
  endfunction

  function automatic void model_step(input logic r, input logic b, input logic s);
    bit bs, ss;
    if (r) begin
      mq_btn.delete();
      mq_sw.delete();
      for (int i = 0; i < S; i++) begin
        mq_btn.push_back(1'b0);
        mq_sw.push_back(1'b0);
      end
      m_level = 1'b0; m_run = 0; m_step = 1'b0; m_w = 1'b0; m_count = 0;
    end else begin
      mq_btn.push_back(b);
      mq_sw.push_back(s);
      bs = mq_btn.pop_front();
      ss = mq_sw.pop_front();
      m_step = 1'b0;
      if (bs != m_level) begin
        m_run++;
        if (m_run == D + 1) begin
          m_level = bs;
          m_run = 0;
          if (bs) begin
            m_step = 1'b1;
            m_w = ss;
            m_count = (m_count + 1) % 256;
          end
        end
      end else begin
        m_run = 0;
      end
    end
  endfunction

  function automatic logic [1:0] m_state();
    return {m_level, (m_run != 0)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] dut_outs();
    return 32'({bus.step, bus.w_out, bus.btn_level, bus.press_count, bus.state});
  endfunction

  task automatic tick(input logic r, input logic b, input logic s);
    rst = r;
    bus.btn_raw = b;
    bus.sw_raw = s;
    @(posedge clk);
    model_step(r, b, s);
    @(negedge clk);
    if (bus.step === 1'b1) steps_seen++;
    check("model", dut_outs(), 32'({m_step, m_w, m_level, m_count[7:0], m_state()}));
  endtask

  task automatic press(input int hold, input int rel, input logic sw_v, input bit toggle);
    for (int i = 0; i < hold; i++) tick(1'b0, 1'b1, sw_v);
    for (int i = 0; i < rel; i++) tick(1'b0, 1'b0, toggle ? i[0] : sw_v);
  endtask

  initial begin
    int s0, idx_hit;
    logic [5:0] bpat;
    logic [4:0] rpat;
    logic b, s;
    int run_len;

    rst = 1'b1;
    bus.btn_raw = 1'b0;
    bus.sw_raw = 1'b0;

    // Clean press then release, one row per clock edge.
    tbl[0]  = v(1, 0, 0, 0, 0, 0, 0, 2'b00);
    tbl[1]  = v(0, 1, 1, 0, 0, 0, 0, 2'b00);
    tbl[2]  = v(0, 1, 1, 0, 0, 0, 0, 2'b00);
    tbl[3]  = v(0, 1, 1, 0, 0, 0, 0, 2'b01);
    tbl[4]  = v(0, 1, 1, 0, 0, 0, 0, 2'b01);
    tbl[5]  = v(0, 1, 1, 0, 0, 0, 0, 2'b01);
    tbl[6]  = v(0, 1, 1, 0, 0, 0, 0, 2'b01);
    tbl[7]  = v(0, 1, 1, 1, 1, 1, 1, 2'b10);
    tbl[8]  = v(0, 1, 1, 0, 1, 1, 1, 2'b10);
    tbl[9]  = v(0, 1, 1, 0, 1, 1, 1, 2'b10);
    tbl[10] = v(0, 1, 1, 0, 1, 1, 1, 2'b10);
    tbl[11] = v(0, 0, 0, 0, 1, 1, 1, 2'b10);
    tbl[12] = v(0, 0, 0, 0, 1, 1, 1, 2'b10);
    tbl[13] = v(0, 0, 0, 0, 1, 1, 1, 2'b11);
    tbl[14] = v(0, 0, 0, 0, 1, 1, 1, 2'b11);
    tbl[15] = v(0, 0, 0, 0, 1, 1, 1, 2'b11);
    tbl[16] = v(0, 0, 0, 0, 1, 1, 1, 2'b11);
    tbl[17] = v(0, 0, 0, 0, 1, 0, 1, 2'b00);
    tbl[18] = v(0, 0, 0, 0, 1, 0, 1, 2'b00);

    for (int i = 0; i < 19; i++) begin
      tick(tbl[i].rst, tbl[i].btn, tbl[i].sw);
      check($sformatf("table[%0d]", i), dut_outs(),
            32'({tbl[i].step, tbl[i].w, tbl[i].lvl, tbl[i].cnt, tbl[i].st}));
    end

    // Press bounce 1,1,0,1,1,0 then steady 1: one step, 6 edges after steady starts.
    tick(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) tick(1'b0, 1'b0, 1'b0);
    bpat = 6'b011011;
    s0 = steps_seen;
    idx_hit = -1;
    for (int i = 0; i < 18; i++) begin
      tick(1'b0, (i < 6) ? bpat[i] : 1'b1, 1'b0);
      if (bus.step === 1'b1 && idx_hit < 0) idx_hit = i;
    end
    check("bounce_step_edge", 32'(idx_hit), 32'd12);
    check("bounce_step_count", 32'(steps_seen - s0), 32'd1);
    check("bounce_press_count", 32'(bus.press_count), 32'd1);

    // Release bounce 0,1,0,0,1 then steady 0: IDLE only after the full stable window.
    rpat = 5'b10010;
    s0 = steps_seen;
    idx_hit = -1;
    for (int i = 0; i < 14; i++) begin
      tick(1'b0, (i < 5) ? rpat[i] : 1'b0, 1'b0);
      if (bus.state === 2'b00 && idx_hit < 0) idx_hit = i;
    end
    check("release_idle_edge", 32'(idx_hit), 32'd11);
    check("release_no_step", 32'(steps_seen - s0), 32'd0);
    s0 = steps_seen;
    press(12, 10, 1'b0, 1'b0);
    check("repress_step_count", 32'(steps_seen - s0), 32'd1);
    check("repress_press_count", 32'(bus.press_count), 32'd2);

    // w capture: sw=1 for press 1, toggling afterwards, sw=0 for press 2.
    press(10, 10, 1'b1, 1'b1);
    check("w_after_press1", 32'(bus.w_out), 32'd1);
    press(10, 10, 1'b0, 1'b0);
    check("w_after_press2", 32'(bus.w_out), 32'd0);

    // Reset in PRESS_WAIT with cnt=2, button held through reset release.
    tick(1'b1, 1'b0, 1'b0);
    press(10, 10, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) tick(1'b0, 1'b1, 1'b1);
    check("pre_reset_state", 32'(bus.state), 32'd1);
    tick(1'b1, 1'b1, 1'b1);
    check("reset_outs", dut_outs(), 32'd0);
    s0 = steps_seen;
    idx_hit = -1;
    for (int i = 0; i < 12; i++) begin
      tick(1'b0, 1'b1, 1'b1);
      if (bus.step === 1'b1 && idx_hit < 0) idx_hit = i;
    end
    check("held_reset_step_edge", 32'(idx_hit), 32'd6);
    check("held_reset_step_count", 32'(steps_seen - s0), 32'd1);
    press(0, 10, 1'b0, 1'b0);

    // Wrap: 256 clean presses from a fresh reset.
    tick(1'b1, 1'b0, 1'b0);
    s0 = steps_seen;
    for (int n = 0; n < 255; n++) press(7, 8, n[0], 1'b0);
    check("wrap_count_255", 32'(bus.press_count), 32'd255);
    press(7, 8, 1'b1, 1'b0);
    check("wrap_count_0", 32'(bus.press_count), 32'd0);
    check("wrap_steps", 32'(steps_seen - s0), 32'd256);

    // Random runs of button levels with random switch and rare resets.
    for (int n = 0; n < 600; n++) begin
      b = 1'($urandom_range(0, 1));
      run_len = $urandom_range(1, 9);
      for (int k = 0; k < run_len; k++) begin
        s = 1'($urandom_range(0, 1));
        tick(($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0, b, s);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
